// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register ids, status codes,
// decode-stage state encoding and the register-specifier decode functions.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] ICODE_HALT   = 4'd0;
  localparam logic [3:0] ICODE_NOP    = 4'd1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'd2;   // also cmovXX
  localparam logic [3:0] ICODE_IRMOVQ = 4'd3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'd4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'd5;
  localparam logic [3:0] ICODE_OPQ    = 4'd6;
  localparam logic [3:0] ICODE_JXX    = 4'd7;
  localparam logic [3:0] ICODE_CALL   = 4'd8;
  localparam logic [3:0] ICODE_RET    = 4'd9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'd10;
  localparam logic [3:0] ICODE_POPQ   = 4'd11;

  // Register identifiers
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  // Processor status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Run/halt state of the write-back stage
  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } wb_state_t;

  // Source A: rA for cmov/rmmovq/OPq/pushq, %rsp for ret/popq
  function automatic logic [3:0] f_src_a(input logic [3:0] icode, input logic [3:0] ra);
    logic [3:0] v;
    case (icode)
      ICODE_RRMOVQ, ICODE_RMMOVQ, ICODE_OPQ, ICODE_PUSHQ: v = ra;
      ICODE_RET, ICODE_POPQ:                              v = RRSP;
      default:                                            v = RNONE;
    endcase
    return v;
  endfunction

  // Source B: rB for memory/OPq, %rsp for stack instructions
  function automatic logic [3:0] f_src_b(input logic [3:0] icode, input logic [3:0] rb);
    logic [3:0] v;
    case (icode)
      ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_OPQ:               v = rb;
      ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ:      v = RRSP;
      default:                                             v = RNONE;
    endcase
    return v;
  endfunction

  // Destination E: rB for irmovq/OPq and taken cmov, %rsp for stack instructions
  function automatic logic [3:0] f_dst_e(input logic [3:0] icode, input logic [3:0] rb,
                                         input logic cnd);
    logic [3:0] v;
    case (icode)
      ICODE_IRMOVQ, ICODE_OPQ:                             v = rb;
      ICODE_RRMOVQ:                                        v = cnd ? rb : RNONE;
      ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ:      v = RRSP;
      default:                                             v = RNONE;
    endcase
    return v;
  endfunction

  // Destination M: rA for mrmovq/popq
  function automatic logic [3:0] f_dst_m(input logic [3:0] icode, input logic [3:0] ra);
    logic [3:0] v;
    case (icode)
      ICODE_MRMOVQ, ICODE_POPQ: v = ra;
      default:                  v = RNONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// 15-entry register file: two asynchronous read ports, two synchronous write
// ports. When both write ports hit the same register, port M wins.
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RSP_RESET = {XLEN{1'b0}}
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we_e,
  input  logic [3:0]      dst_e,
  input  logic [XLEN-1:0] val_e,
  input  logic            we_m,
  input  logic [3:0]      dst_m,
  input  logic [XLEN-1:0] val_m,
  input  logic [3:0]      src_a,
  input  logic [3:0]      src_b,
  output logic [XLEN-1:0] rd_a,
  output logic [XLEN-1:0] rd_b
);

  logic [XLEN-1:0] r_regs [0:14];

  // Register storage: reset image, then port-M-over-port-E write priority
  always_ff @(posedge clock) begin
    for (int i = 0; i < 15; i++) begin
      if (reset) begin
        r_regs[i] <= (4'(i) == RRSP) ? RSP_RESET : {XLEN{1'b0}};
      end else if (we_m && (dst_m == 4'(i))) begin
        r_regs[i] <= val_m;
      end else if (we_e && (dst_e == 4'(i))) begin
        r_regs[i] <= val_e;
      end else begin
        r_regs[i] <= r_regs[i];
      end
    end
  end

  // Read ports: RNONE reads as zero, no write bypass
  always_comb begin
    rd_a = {XLEN{1'b0}};
    rd_b = {XLEN{1'b0}};
    if (src_a != RNONE) begin
      rd_a = r_regs[src_a];
    end else begin
      rd_a = {XLEN{1'b0}};
    end
    if (src_b != RNONE) begin
      rd_b = r_regs[src_b];
    end else begin
      rd_b = {XLEN{1'b0}};
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode and write-back stage: register specifier decode, operand
// reads, commit-time write-back, sticky processor status and retire counter.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RSP_RESET = {XLEN{1'b0}}
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            commit,
  input  logic [3:0]      icode,
  input  logic [3:0]      ra,
  input  logic [3:0]      rb,
  input  logic            cnd,
  input  logic [XLEN-1:0] vale,
  input  logic [XLEN-1:0] valm,
  input  logic            imem_error,
  input  logic            instr_valid,
  input  logic            dmem_error,
  output logic [XLEN-1:0] vala,
  output logic [XLEN-1:0] valb,
  output logic [2:0]      stat,
  output logic            halted,
  output logic [63:0]     instr_count
);

  wb_state_t   r_state;
  wb_state_t   w_state_next;
  logic [2:0]  r_stat;
  logic        r_halted;
  logic [63:0] r_instr_count;

  logic [3:0]  w_src_a;
  logic [3:0]  w_src_b;
  logic [3:0]  w_dst_e;
  logic [3:0]  w_dst_m;
  logic [2:0]  w_instr_stat;
  logic        w_retire_ok;
  logic        w_fault_commit;

  // Register specifier decode
  always_comb begin
    w_src_a = f_src_a(icode, ra);
    w_src_b = f_src_b(icode, rb);
    w_dst_e = f_dst_e(icode, rb, cnd);
    w_dst_m = f_dst_m(icode, ra);
  end

  // Status of the instruction in flight: address faults beat illegal, illegal beats halt
  always_comb begin
    w_instr_stat = STAT_AOK;
    if (imem_error || dmem_error) begin
      w_instr_stat = STAT_ADR;
    end else if (!instr_valid) begin
      w_instr_stat = STAT_INS;
    end else if (icode == ICODE_HALT) begin
      w_instr_stat = STAT_HLT;
    end else begin
      w_instr_stat = STAT_AOK;
    end
  end

  // Commit qualifiers: clean retire writes back, a non-AOK commit stops the machine
  always_comb begin
    w_retire_ok    = commit && (r_state == S_RUN) && (w_instr_stat == STAT_AOK);
    w_fault_commit = commit && (r_state == S_RUN) && (w_instr_stat != STAT_AOK);
  end

  // Run/halt next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN: begin
        if (w_fault_commit) begin
          w_state_next = S_HALTED;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sticky status and halted flag: latch the first non-AOK code
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat   <= STAT_AOK;
      r_halted <= 1'b0;
    end else if (w_fault_commit) begin
      r_stat   <= w_instr_stat;
      r_halted <= 1'b1;
    end else begin
      r_stat   <= r_stat;
      r_halted <= r_halted;
    end
  end

  // Retired-instruction counter, wraps modulo 2^64
  always_ff @(posedge clock) begin
    if (reset) begin
      r_instr_count <= 64'd0;
    end else if (w_retire_ok) begin
      r_instr_count <= r_instr_count + 64'd1;
    end else begin
      r_instr_count <= r_instr_count;
    end
  end

  regfile_2r2w #(
    .XLEN      (XLEN),
    .RSP_RESET (RSP_RESET)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .we_e  (w_retire_ok),
    .dst_e (w_dst_e),
    .val_e (vale),
    .we_m  (w_retire_ok),
    .dst_m (w_dst_m),
    .val_m (valm),
    .src_a (w_src_a),
    .src_b (w_src_b),
    .rd_a  (vala),
    .rd_b  (valb)
  );

  assign stat        = r_stat;
  assign halted      = r_halted;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_decode_writeback.sv
// Directed self-checking bench for decode_writeback.
module tb_decode_writeback;

  localparam int          XLEN  = 64;
  localparam logic [63:0] RSP_R = 64'h0000_0000_0000_1000;

  logic            clock;
  logic            reset;
  logic            commit;
  logic [3:0]      icode;
  logic [3:0]      ra;
  logic [3:0]      rb;
  logic            cnd;
  logic [XLEN-1:0] vale;
  logic [XLEN-1:0] valm;
  logic            imem_error;
  logic            instr_valid;
  logic            dmem_error;
  logic [XLEN-1:0] vala;
  logic [XLEN-1:0] valb;
  logic [2:0]      stat;
  logic            halted;
  logic [63:0]     instr_count;

  int checks;
  int errors;

  decode_writeback #(.XLEN(XLEN), .RSP_RESET(RSP_R)) dut (
    .clock       (clock),
    .reset       (reset),
    .commit      (commit),
    .icode       (icode),
    .ra          (ra),
    .rb          (rb),
    .cnd         (cnd),
    .vale        (vale),
    .valm        (valm),
    .imem_error  (imem_error),
    .instr_valid (instr_valid),
    .dmem_error  (dmem_error),
    .vala        (vala),
    .valb        (valb),
    .stat        (stat),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // drive a clean (fault-free) instruction
  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m,
                       input logic cm);
    icode = ic; ra = a; rb = b; cnd = c; vale = e; valm = m; commit = cm;
    imem_error = 1'b0; dmem_error = 1'b0; instr_valid = 1'b1;
    #1;
  endtask

  // read a register through the OPq srcA decode path without committing
  task automatic read_reg(input logic [3:0] r, output logic [63:0] v);
    drive(4'd6, r, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    v = vala;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'd1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    do_reset();
    checks++; if (stat !== 3'd1) begin errors++; $display("FAIL reset_stat got %0d want 1", stat); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
    checks++; if (instr_count !== 64'd0) begin errors++; $display("FAIL reset_count got %0d want 0", instr_count); end
    read_reg(4'd4, v);
    checks++; if (v !== RSP_R) begin errors++; $display("FAIL reset_r4 got %h want %h", v, RSP_R); end
    read_reg(4'd3, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL reset_r3 got %h want 0", v); end
  endtask

  task automatic test_irmovq();
    logic [63:0] v;
    drive(4'd3, 4'hF, 4'd3, 1'b0, 64'h2A, 64'd0, 1'b1);
    tick();
    read_reg(4'd3, v);
    checks++; if (v !== 64'h2A) begin errors++; $display("FAIL irmovq_r3 got %h want 2a", v); end
    checks++; if (instr_count !== 64'd1) begin errors++; $display("FAIL irmovq_count got %0d want 1", instr_count); end
    checks++; if (stat !== 3'd1) begin errors++; $display("FAIL irmovq_stat got %0d want 1", stat); end
  endtask

  task automatic test_opq_cmov();
    logic [63:0] v;
    drive(4'd6, 4'd3, 4'd5, 1'b0, 64'd0, 64'd0, 1'b0);
    checks++; if (vala !== 64'h2A) begin errors++; $display("FAIL opq_vala got %h want 2a", vala); end
    checks++; if (valb !== 64'd0) begin errors++; $display("FAIL opq_valb got %h want 0", valb); end
    drive(4'd2, 4'd3, 4'd6, 1'b0, 64'd7, 64'd0, 1'b1);
    tick();
    read_reg(4'd6, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL cmov_nt_r6 got %h want 0", v); end
    checks++; if (instr_count !== 64'd2) begin errors++; $display("FAIL cmov_nt_count got %0d want 2", instr_count); end
    drive(4'd2, 4'd3, 4'd6, 1'b1, 64'd7, 64'd0, 1'b1);
    tick();
    read_reg(4'd6, v);
    checks++; if (v !== 64'd7) begin errors++; $display("FAIL cmov_t_r6 got %h want 7", v); end
  endtask

  task automatic test_pop_push();
    logic [63:0] v;
    drive(4'd11, 4'd4, 4'hF, 1'b0, 64'h108, 64'hBEEF, 1'b1);
    checks++; if (vala !== RSP_R) begin errors++; $display("FAIL popq_vala got %h want %h", vala, RSP_R); end
    checks++; if (valb !== RSP_R) begin errors++; $display("FAIL popq_valb got %h want %h", valb, RSP_R); end
    tick();
    read_reg(4'd4, v);
    checks++; if (v !== 64'hBEEF) begin errors++; $display("FAIL popq_r4 got %h want beef", v); end
    drive(4'd10, 4'd3, 4'hF, 1'b0, 64'hBEE7, 64'd0, 1'b1);
    checks++; if (valb !== 64'hBEEF) begin errors++; $display("FAIL pushq_valb got %h want beef", valb); end
    checks++; if (vala !== 64'h2A) begin errors++; $display("FAIL pushq_vala got %h want 2a", vala); end
    tick();
    read_reg(4'd4, v);
    checks++; if (v !== 64'hBEE7) begin errors++; $display("FAIL pushq_r4 got %h want bee7", v); end
    checks++; if (instr_count !== 64'd5) begin errors++; $display("FAIL pushq_count got %0d want 5", instr_count); end
  endtask

  task automatic test_fault();
    logic [63:0] v;
    drive(4'd5, 4'd7, 4'd3, 1'b0, 64'h10, 64'h55, 1'b1);
    dmem_error = 1'b1;
    tick();
    dmem_error = 1'b0;
    read_reg(4'd7, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL adr_r7 got %h want 0", v); end
    checks++; if (stat !== 3'd3) begin errors++; $display("FAIL adr_stat got %0d want 3", stat); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL adr_halted got %0b want 1", halted); end
    checks++; if (instr_count !== 64'd5) begin errors++; $display("FAIL adr_count got %0d want 5", instr_count); end
    drive(4'd3, 4'hF, 4'd3, 1'b0, 64'h99, 64'd0, 1'b1);
    tick();
    drive(4'd0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
    tick();
    read_reg(4'd3, v);
    checks++; if (v !== 64'h2A) begin errors++; $display("FAIL halted_r3 got %h want 2a", v); end
    checks++; if (stat !== 3'd3) begin errors++; $display("FAIL halted_stat got %0d want 3", stat); end
    checks++; if (instr_count !== 64'd5) begin errors++; $display("FAIL halted_count got %0d want 5", instr_count); end
  endtask

  task automatic test_halt_status();
    logic [63:0] v;
    do_reset();
    drive(4'd0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
    tick();
    checks++; if (stat !== 3'd2) begin errors++; $display("FAIL hlt_stat got %0d want 2", stat); end
    checks++; if (instr_count !== 64'd0) begin errors++; $display("FAIL hlt_count got %0d want 0", instr_count); end
    do_reset();
    drive(4'd3, 4'hF, 4'd3, 1'b0, 64'h33, 64'd0, 1'b1);
    instr_valid = 1'b0; imem_error = 1'b1;
    tick();
    imem_error = 1'b0; instr_valid = 1'b1;
    checks++; if (stat !== 3'd3) begin errors++; $display("FAIL adr_prio_stat got %0d want 3", stat); end
    read_reg(4'd3, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL adr_prio_r3 got %h want 0", v); end
    do_reset();
    drive(4'd3, 4'hF, 4'd3, 1'b0, 64'h33, 64'd0, 1'b1);
    instr_valid = 1'b0;
    tick();
    instr_valid = 1'b1;
    checks++; if (stat !== 3'd4) begin errors++; $display("FAIL ins_stat got %0d want 4", stat); end
    do_reset();
    checks++; if (stat !== 3'd1) begin errors++; $display("FAIL rerst_stat got %0d want 1", stat); end
    read_reg(4'd4, v);
    checks++; if (v !== RSP_R) begin errors++; $display("FAIL rerst_r4 got %h want %h", v, RSP_R); end
  endtask

  task automatic test_wrap_and_reset_commit();
    logic [63:0] v;
    force dut.r_instr_count = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instr_count;
    drive(4'd3, 4'hF, 4'd2, 1'b0, 64'h5, 64'd0, 1'b1);
    tick();
    checks++; if (instr_count !== 64'd0) begin errors++; $display("FAIL wrap_count got %h want 0", instr_count); end
    read_reg(4'd2, v);
    checks++; if (v !== 64'h5) begin errors++; $display("FAIL wrap_r2 got %h want 5", v); end
    drive(4'd3, 4'hF, 4'd3, 1'b0, 64'h77, 64'd0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_reg(4'd3, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL rst_commit_r3 got %h want 0", v); end
    read_reg(4'd2, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL rst_commit_r2 got %h want 0", v); end
    checks++; if (instr_count !== 64'd0) begin errors++; $display("FAIL rst_commit_count got %0d want 0", instr_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    commit = 1'b0; icode = 4'd1; ra = 4'hF; rb = 4'hF; cnd = 1'b0;
    vale = 64'd0; valm = 64'd0;
    imem_error = 1'b0; instr_valid = 1'b1; dmem_error = 1'b0;
    #1;
    test_reset();
    test_irmovq();
    test_opq_cmov();
    test_pop_push();
    test_fault();
    test_halt_status();
    test_wrap_and_reset_commit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
